ir_line_follow_ctrl: RTL and testbench
======================================

Name: ir_line_follow_ctrl

Overview:
- Controller for the two external IR line sensors on D13 (left) and D12 (right).
- Synchronises and debounces both sensor inputs and mirrors the filtered values on LED0/LED1.
- Runs a line-follower state machine that drives two 2-bit motor commands to a downstream motor/servo driver.
- Includes a bounded search phase when the line is lost.

Parameters:
- DEBOUNCE, 16: consecutive clocks a synchronised input must hold a new level before the filtered value changes (valid range 1..65535).
- SEARCH_CYCLES, 1200000: maximum clocks spent spinning in SEARCH before giving up to STOP (valid range 1..2^24-1).

Ports:
- clk  in  1  system clock (12 MHz board clock)
- rst  in  1  synchronous reset, active-high
- en  in  1  run enable; low forces IDLE
- ir_left  in  1  raw left sensor (D13), 1 = line detected, asynchronous
- ir_right  in  1  raw right sensor (D12), 1 = line detected, asynchronous
- led_left  out  1  filtered left sensor (to LED0)
- led_right  out  1  filtered right sensor (to LED1)
- motor_l  out  2  left motor command: 00 stop, 01 forward, 10 reverse; 11 never driven
- motor_r  out  2  right motor command, same encoding
- lost  out  1  high while in SEARCH or STOP

Behaviour:
- Reset: all of the following are cleared to 0, and the state machine goes to IDLE:
  - sync flops, filtered values, debounce and search counters
  - led_left, led_right, motor_l, motor_r, lost
- Synchroniser: 2-flop chain per input; sync flops are cleared by reset like any register.
- Debounce, per sensor:
  - The counter clears whenever the sync value equals the filtered value.
  - Otherwise the counter increments each clock.
  - When the counter reaches DEBOUNCE-1 while still differing, the filtered value takes the sync value on that edge and the counter clears.
  - Pulses shorter than DEBOUNCE clocks are ignored.
  - Latency from a stable raw change to the filtered/LED change is DEBOUNCE+2 clocks.
- LEDs: led_* equal the filtered values (registered), independent of en and of state.
- State machine: registered; it evaluates the filtered values F=(L,R) each clock, and the outputs change on the clock after F changes.
  - IDLE: motors 00/00.
    - en=1 with F=11 → FWD
    - en=1 with F=10 → LEFT
    - en=1 with F=01 → RIGHT
    - en=1 with F=00 → STOP
  - FWD: motor_l=01, motor_r=01.
    - F=10 → LEFT
    - F=01 → RIGHT
    - F=00 → SEARCH
  - LEFT: motor_l=00, motor_r=01. Sets the last_dir register to left.
    - F=11 → FWD
    - F=01 → RIGHT
    - F=00 → SEARCH
  - RIGHT: motor_l=01, motor_r=00. Sets last_dir to right.
    - F=11 → FWD
    - F=10 → LEFT
    - F=00 → SEARCH
  - SEARCH: spins toward last_dir (left: motor_l=10, motor_r=01; right: motor_l=01, motor_r=10). lost=1.
    - The search counter clears on entry and increments each clock in SEARCH.
    - Any F≠00 → the corresponding FWD/LEFT/RIGHT state; this has priority over the timeout in the same cycle.
    - The counter reaching SEARCH_CYCLES-1 with F=00 → STOP.
  - STOP: motors 00/00, lost=1.
    - Any F≠00 → the corresponding FWD/LEFT/RIGHT state.
- last_dir: resets to left. It is updated only in the LEFT and RIGHT states and is held across IDLE.
- en=0 in any state → IDLE on the next clock, with motors 00/00 and lost=0. en has priority over all other transitions.
- Motor outputs and lost are registered and decoded from the next state, so they are valid in the same cycle the state register updates.
- rst asserted mid-operation: all outputs return to 0 on the next edge; debounce history is lost, so the filtered values restart at 0.

Test Plan (DEBOUNCE=4, SEARCH_CYCLES=20):
- Reset then hold rst low, en=1, ir=11 → led=11 after 6 clocks; state FWD with motors 01/01 on clock 7; lost=0.
- Glitch: pulse ir_left low for 3 clocks while in FWD → led_left stays 1 and motors stay 01/01 throughout.
- From FWD, ir=10 stable → LEFT (00/01) 7 clocks later; then ir=00 → SEARCH with motors 10/01 and lost=1.
- ir=00 held → SEARCH lasts exactly 20 clocks, then STOP (00/00, lost=1); ir=01 → RIGHT (01/00) and lost=0.
- In SEARCH, the filtered value becomes 11 on the same clock the search counter hits 19 → next state is FWD, not STOP.
- en dropped in RIGHT → IDLE, motors 00/00 next clock while LEDs keep tracking the sensors; rst pulse in SEARCH → all outputs 0, LEDs 0 until re-debounced.

Source files
------------

// File: rtl/ir_line_follow_ctrl.sv
// IR line-follower controller: synchronises and debounces the two line sensors,
// mirrors them on the LEDs and steers two motor commands, with a bounded search.
module ir_line_follow_ctrl #(
  parameter int unsigned DEBOUNCE      = 16,
  parameter int unsigned SEARCH_CYCLES = 1200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ir_left,
  input  logic       ir_right,
  output logic       led_left,
  output logic       led_right,
  output logic [1:0] motor_l,
  output logic [1:0] motor_r,
  output logic       lost
);

  localparam logic [15:0] DB_MAX     = 16'(DEBOUNCE - 1);
  localparam logic [23:0] SEARCH_MAX = 24'(SEARCH_CYCLES - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FWD    = 3'd1;
  localparam logic [2:0] ST_LEFT   = 3'd2;
  localparam logic [2:0] ST_RIGHT  = 3'd3;
  localparam logic [2:0] ST_SEARCH = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;

  localparam logic [1:0] MOT_STOP = 2'b00;
  localparam logic [1:0] MOT_FWD  = 2'b01;
  localparam logic [1:0] MOT_REV  = 2'b10;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Sensor vectors are packed as {left, right}.
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       filt_q, filt_d;
  logic [1:0][15:0] db_cnt_q, db_cnt_d;

  logic [2:0]  state_q, state_d;
  logic [23:0] srch_cnt_q, srch_cnt_d;
  logic        last_dir_q, last_dir_d;

  logic       led_left_q, led_left_d;
  logic       led_right_q, led_right_d;
  logic [1:0] motor_l_q, motor_l_d;
  logic [1:0] motor_r_q, motor_r_d;
  logic       lost_q, lost_d;

  // Tracking state for a non-zero filtered pattern; lost_state is used for 00.
  function automatic logic [2:0] track_state(input logic [1:0] f, input logic [2:0] lost_state);
    logic [2:0] nxt;
    case (f)
      2'b11:   nxt = ST_FWD;
      2'b10:   nxt = ST_LEFT;
      2'b01:   nxt = ST_RIGHT;
      default: nxt = lost_state;
    endcase
    return nxt;
  endfunction

  // Motor pair {left, right} for a given state; search spins toward the last seen side.
  function automatic logic [3:0] motor_decode(input logic [2:0] st, input logic dir);
    logic [3:0] m;
    case (st)
      ST_FWD:   m = {MOT_FWD, MOT_FWD};
      ST_LEFT:  m = {MOT_STOP, MOT_FWD};
      ST_RIGHT: m = {MOT_FWD, MOT_STOP};
      ST_SEARCH: begin
        if (dir == DIR_LEFT) begin
          m = {MOT_REV, MOT_FWD};
        end else begin
          m = {MOT_FWD, MOT_REV};
        end
      end
      default:  m = {MOT_STOP, MOT_STOP};
    endcase
    return m;
  endfunction

  // Two-flop synchroniser for the asynchronous sensor inputs.
  always_comb begin
    sync1_d = {ir_left, ir_right};
    sync2_d = sync1_q;
  end

  // Per-sensor debounce: a new level must persist DEBOUNCE clocks to be accepted.
  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        db_cnt_d[i] = 16'd0;
      end else if (db_cnt_q[i] == DB_MAX) begin
        filt_d[i]   = sync2_q[i];
        db_cnt_d[i] = 16'd0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 16'd1;
      end
    end
  end

  // Line-follower next state; en low overrides everything.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:                 state_d = track_state(filt_q, ST_STOP);
        ST_FWD, ST_LEFT, ST_RIGHT: state_d = track_state(filt_q, ST_SEARCH);
        ST_SEARCH: begin
          // Reacquiring the line wins over the timeout in the same cycle.
          if (filt_q != 2'b00) begin
            state_d = track_state(filt_q, ST_SEARCH);
          end else if (srch_cnt_q == SEARCH_MAX) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_SEARCH;
          end
        end
        ST_STOP:                 state_d = track_state(filt_q, ST_STOP);
        default:                 state_d = ST_IDLE;
      endcase
    end
  end

  // Search counter runs only while in SEARCH and is zero on entry.
  always_comb begin
    if (state_q == ST_SEARCH) begin
      srch_cnt_d = srch_cnt_q + 24'd1;
    end else begin
      srch_cnt_d = 24'd0;
    end
  end

  // Remember the side last steered toward; held through every other state.
  always_comb begin
    case (state_d)
      ST_LEFT:  last_dir_d = DIR_LEFT;
      ST_RIGHT: last_dir_d = DIR_RIGHT;
      default:  last_dir_d = last_dir_q;
    endcase
  end

  // Outputs decoded from the next state so they align with the state register.
  always_comb begin
    led_left_d           = filt_d[1];
    led_right_d          = filt_d[0];
    {motor_l_d, motor_r_d} = motor_decode(state_d, last_dir_d);
    if ((state_d == ST_SEARCH) || (state_d == ST_STOP)) begin
      lost_d = 1'b1;
    end else begin
      lost_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 2'b00;
      sync2_q     <= 2'b00;
      filt_q      <= 2'b00;
      db_cnt_q    <= '0;
      state_q     <= ST_IDLE;
      srch_cnt_q  <= 24'd0;
      last_dir_q  <= DIR_LEFT;
      led_left_q  <= 1'b0;
      led_right_q <= 1'b0;
      motor_l_q   <= MOT_STOP;
      motor_r_q   <= MOT_STOP;
      lost_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      filt_q      <= filt_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      srch_cnt_q  <= srch_cnt_d;
      last_dir_q  <= last_dir_d;
      led_left_q  <= led_left_d;
      led_right_q <= led_right_d;
      motor_l_q   <= motor_l_d;
      motor_r_q   <= motor_r_d;
      lost_q      <= lost_d;
    end
  end

  assign led_left  = led_left_q;
  assign led_right = led_right_q;
  assign motor_l   = motor_l_q;
  assign motor_r   = motor_r_q;
  assign lost      = lost_q;

endmodule

// File: tb/tb_ir_line_follow_ctrl.sv
// Directed bench for ir_line_follow_ctrl with DEBOUNCE=4, SEARCH_CYCLES=20.
module tb_ir_line_follow_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic       ir_left;
  logic       ir_right;
  logic       led_left;
  logic       led_right;
  logic [1:0] motor_l;
  logic [1:0] motor_r;
  logic       lost;

  int total_cnt;
  int bad_cnt;

  ir_line_follow_ctrl #(
    .DEBOUNCE      (4),
    .SEARCH_CYCLES (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .ir_left   (ir_left),
    .ir_right  (ir_right),
    .led_left  (led_left),
    .led_right (led_right),
    .motor_l   (motor_l),
    .motor_r   (motor_r),
    .lost      (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {led_l, led_r, motor_l, motor_r, lost}.
  function automatic logic [6:0] outs();
    return {led_left, led_right, motor_l, motor_r, lost};
  endfunction

  task automatic check_val(input string tag, input logic [6:0] got, input logic [6:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %b expected %b (led_l led_r motor_l motor_r lost)", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
    end
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst = 1'b1; en = 1'b0; ir_left = 1'b0; ir_right = 1'b0;
    ticks(2);
    check_val("reset", outs(), 7'b00_00_00_0);
    en = 1'b1; ir_left = 1'b1; ir_right = 1'b1;
    tick();
    check_val("reset_hold", outs(), 7'b00_00_00_0);
    rst = 1'b0;

    // Filtered 00 with en=1 sends IDLE to STOP until the sensors settle.
    ticks(5);
    check_val("pre_led", outs(), 7'b00_00_00_1);
    tick();
    check_val("led_on", outs(), 7'b11_00_00_1);
    tick();
    check_val("fwd", outs(), 7'b11_01_01_0);

    // Three-clock dropout on the left sensor must be rejected.
    ir_left = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i == 3) ir_left = 1'b1;
      tick();
      check_val("glitch", outs(), 7'b11_01_01_0);
    end

    ir_right = 1'b0;
    ticks(6);
    check_val("pre_left", outs(), 7'b10_01_01_0);
    tick();
    check_val("left", outs(), 7'b10_00_01_0);

    ir_left = 1'b0;
    ticks(6);
    check_val("pre_search", outs(), 7'b00_00_01_0);
    tick();
    check_val("search_l", outs(), 7'b00_10_01_1);
    for (int i = 0; i < 19; i++) begin
      tick();
      check_val("search_hold", outs(), 7'b00_10_01_1);
    end
    tick();
    check_val("stop", outs(), 7'b00_00_00_1);

    ir_right = 1'b1;
    ticks(6);
    check_val("pre_right", outs(), 7'b01_00_00_1);
    tick();
    check_val("right", outs(), 7'b01_01_00_0);

    // Lose the line after RIGHT, then reacquire exactly as the timeout count is reached.
    ir_right = 1'b0;
    ticks(7);
    check_val("search_r", outs(), 7'b00_01_10_1);
    ticks(13);
    ir_left = 1'b1; ir_right = 1'b1;
    ticks(6);
    check_val("race_pre", outs(), 7'b11_01_10_1);
    tick();
    check_val("race_fwd", outs(), 7'b11_01_01_0);

    ir_left = 1'b0;
    ticks(7);
    check_val("right2", outs(), 7'b01_01_00_0);
    en = 1'b0; ir_left = 1'b1;
    tick();
    check_val("idle", outs(), 7'b01_00_00_0);
    ticks(4);
    check_val("idle_led_pre", outs(), 7'b01_00_00_0);
    tick();
    check_val("idle_led", outs(), 7'b11_00_00_0);
    en = 1'b1;
    tick();
    check_val("resume_fwd", outs(), 7'b11_01_01_0);

    // last_dir is still right from the RIGHT state before IDLE.
    ir_left = 1'b0; ir_right = 1'b0;
    ticks(7);
    check_val("search3", outs(), 7'b00_01_10_1);
    rst = 1'b1; ir_left = 1'b1; ir_right = 1'b1;
    tick();
    check_val("rst_mid", outs(), 7'b00_00_00_0);
    rst = 1'b0;
    ticks(5);
    check_val("rerise_pre", outs(), 7'b00_00_00_1);
    tick();
    check_val("rerise", outs(), 7'b11_00_00_1);
    tick();
    check_val("rerise_fwd", outs(), 7'b11_01_01_0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
